// File: rtl/countdown_timer.sv
// Settable hh:mm:ss.cc countdown timer. Produces the packed 27-bit time word
// {hr[4:0], min[5:0], sec[5:0], cc[6:0], 3'b000} for the display mode mux.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        toggle,
  input  logic        add_one,
  input  logic        add_ten,
  input  logic        ms_sw,
  input  logic        s_sw,
  input  logic        min_sw,
  input  logic        hr_sw,
  output logic [26:0] out_time,
  output logic        running,
  output logic        done
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [4:0]    hr, hr_d;
  logic [5:0]    mn, mn_d;
  logic [5:0]    sc, sc_d;
  logic [6:0]    cc, cc_d;
  logic [PW-1:0] cnt, cnt_d;
  logic          toggle_q, add_one_q, add_ten_q;
  logic          running_q, done_q;

  logic       tog_e, one_e, ten_e;
  logic       tick, time_zero, edit_en;
  logic       borrow_s, borrow_m, borrow_h;
  logic [6:0] inc;

  assign tog_e     = toggle  & ~toggle_q;
  assign one_e     = add_one & ~add_one_q;
  assign ten_e     = add_ten & ~add_ten_q;
  assign tick      = (cnt == PW'(TICK_DIV - 1));
  assign time_zero = ({hr, mn, sc, cc} == '0);
  assign inc       = (ten_e ? 7'd10 : 7'd0) + (one_e ? 7'd1 : 7'd0);

  // Sum is at most 99 + 11, so one conditional subtract wraps any field.
  function automatic logic [6:0] add_mod(input logic [6:0] v, input logic [6:0] a,
                                         input logic [6:0] m);
    logic [7:0] s;
    s = {1'b0, v} + {1'b0, a};
    return (s >= {1'b0, m}) ? 7'(s - {1'b0, m}) : s[6:0];
  endfunction

  always_comb begin
    state_d  = state;
    hr_d     = hr;
    mn_d     = mn;
    sc_d     = sc;
    cc_d     = cc;
    cnt_d    = cnt;
    edit_en  = 1'b0;
    borrow_s = 1'b0;
    borrow_m = 1'b0;
    borrow_h = 1'b0;

    case (state)
      ST_SET: begin
        cnt_d = '0;
        if (tog_e) begin
          if (!time_zero) state_d = ST_RUN;
        end else begin
          edit_en = 1'b1;
        end
      end
      ST_RUN: begin
        if (time_zero) begin
          // Reachable only if a PAUSE edit wrapped every field to zero.
          state_d = ST_DONE;
          cnt_d   = '0;
        end else if (tog_e) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          cnt_d    = '0;
          borrow_s = (cc == 7'd0);
          cc_d     = borrow_s ? 7'd99 : cc - 7'd1;
          if (borrow_s) begin
            borrow_m = (sc == 6'd0);
            sc_d     = borrow_m ? 6'd59 : sc - 6'd1;
          end
          if (borrow_m) begin
            borrow_h = (mn == 6'd0);
            mn_d     = borrow_h ? 6'd59 : mn - 6'd1;
          end
          if (borrow_h && hr != 5'd0) hr_d = hr - 5'd1;
          if ({hr_d, mn_d, sc_d, cc_d} == '0) state_d = ST_DONE;
        end else begin
          cnt_d = cnt + PW'(1);
        end
      end
      ST_PAUSE: begin
        if (tog_e) state_d = ST_RUN;
        else       edit_en = 1'b1;
      end
      ST_DONE: begin
        cnt_d = '0;
        if (tog_e) state_d = ST_SET;
      end
      default: state_d = ST_SET;
    endcase

    if (edit_en && (one_e || ten_e)) begin
      if (hr_sw)       hr_d = 5'(add_mod({2'b00, hr}, inc, 7'd24));
      else if (min_sw) mn_d = 6'(add_mod({1'b0, mn}, inc, 7'd60));
      else if (s_sw)   sc_d = 6'(add_mod({1'b0, sc}, inc, 7'd60));
      else if (ms_sw)  cc_d = add_mod(cc, inc, 7'd100);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_SET;
      hr        <= '0;
      mn        <= '0;
      sc        <= '0;
      cc        <= '0;
      cnt       <= '0;
      toggle_q  <= 1'b0;
      add_one_q <= 1'b0;
      add_ten_q <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_d;
      hr        <= hr_d;
      mn        <= mn_d;
      sc        <= sc_d;
      cc        <= cc_d;
      cnt       <= cnt_d;
      toggle_q  <= toggle;
      add_one_q <= add_one;
      add_ten_q <= add_ten;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign out_time = {hr, mn, sc, cc, 3'b000};
  assign running  = running_q;
  assign done     = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: vector table for SET-state editing, plus
// hand-written run / pause / expiry / async-reset sequences.
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        toggle = 1'b0, add_one = 1'b0, add_ten = 1'b0;
  logic        ms_sw = 1'b0, s_sw = 1'b0, min_sw = 1'b0, hr_sw = 1'b0;
  logic [26:0] out_time;
  logic        running, done;

  int ntests = 0;
  int nfail  = 0;

  countdown_timer #(.TICK_DIV(2)) dut (
    .clk(clk), .reset(reset), .toggle(toggle), .add_one(add_one), .add_ten(add_ten),
    .ms_sw(ms_sw), .s_sw(s_sw), .min_sw(min_sw), .hr_sw(hr_sw),
    .out_time(out_time), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tog, one, ten;
    logic [3:0]  sw;      // {hr, min, s, ms}
    logic [26:0] t;
    logic        run, dn;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [26:0] pk(input int h, input int m, input int s, input int c);
    return {5'(h), 6'(m), 6'(s), 7'(c), 3'b000};
  endfunction

  function automatic vec_t mk(input logic tg, input logic o, input logic tn,
                              input logic [3:0] sw, input logic [26:0] t);
    vec_t v;
    v.tog = tg; v.one = o; v.ten = tn; v.sw = sw; v.t = t; v.run = 1'b0; v.dn = 1'b0;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic tg, input logic o, input logic tn, input logic [3:0] sw);
    toggle = tg; add_one = o; add_ten = tn;
    {hr_sw, min_sw, s_sw, ms_sw} = sw;
  endtask

  task automatic chk_t(input string nm, input logic [26:0] got, input logic [26:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: out_time got %0d:%0d:%0d.%0d [%b] expected %0d:%0d:%0d.%0d [%b]", nm,
               got[26:22], got[21:16], got[15:10], got[9:3], got[2:0],
               exp[26:22], exp[21:16], exp[15:10], exp[9:3], exp[2:0]);
    end
  endtask

  task automatic chk_b(input string nm, input logic got, input logic exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [26:0] t, input logic r, input logic d);
    chk_t({nm, ".time"}, out_time, t);
    chk_b({nm, ".running"}, running, r);
    chk_b({nm, ".done"}, done, d);
  endtask

  task automatic pulse(input logic tg, input logic o, input logic tn, input logic [3:0] sw);
    drive(tg, o, tn, sw);
    step();
    drive(1'b0, 1'b0, 1'b0, 4'b0000);
    step();
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    step();
    step();
    #2 reset = 1'b1;
  endtask

  initial begin
    // SET-state editing table; each vector is held one cycle, then released one cycle
    tbl.push_back(mk(1, 0, 0, 4'b0000, pk(0, 0, 0, 0)));   // toggle at zero: stays SET
    tbl.push_back(mk(0, 0, 1, 4'b0010, pk(0, 0, 10, 0)));
    tbl.push_back(mk(0, 0, 1, 4'b0010, pk(0, 0, 20, 0)));
    tbl.push_back(mk(0, 0, 1, 4'b0010, pk(0, 0, 30, 0)));
    tbl.push_back(mk(0, 0, 1, 4'b0010, pk(0, 0, 40, 0)));
    tbl.push_back(mk(0, 0, 1, 4'b0010, pk(0, 0, 50, 0)));
    tbl.push_back(mk(0, 0, 1, 4'b0010, pk(0, 0, 0, 0)));   // 50+10 wraps
    tbl.push_back(mk(0, 0, 1, 4'b0010, pk(0, 0, 10, 0)));
    tbl.push_back(mk(0, 0, 1, 4'b0010, pk(0, 0, 20, 0)));
    tbl.push_back(mk(0, 0, 1, 4'b0010, pk(0, 0, 30, 0)));
    tbl.push_back(mk(0, 0, 1, 4'b0010, pk(0, 0, 40, 0)));
    tbl.push_back(mk(0, 1, 1, 4'b0010, pk(0, 0, 51, 0)));
    tbl.push_back(mk(0, 1, 0, 4'b0010, pk(0, 0, 52, 0)));
    tbl.push_back(mk(0, 1, 0, 4'b0010, pk(0, 0, 53, 0)));
    tbl.push_back(mk(0, 1, 0, 4'b0010, pk(0, 0, 54, 0)));
    tbl.push_back(mk(0, 1, 0, 4'b0010, pk(0, 0, 55, 0)));
    tbl.push_back(mk(0, 1, 1, 4'b0010, pk(0, 0, 6, 0)));   // 55+11 -> 06
    tbl.push_back(mk(0, 1, 0, 4'b1010, pk(1, 0, 6, 0)));   // hr beats s
    tbl.push_back(mk(0, 0, 1, 4'b1000, pk(11, 0, 6, 0)));
    tbl.push_back(mk(0, 0, 1, 4'b1000, pk(21, 0, 6, 0)));
    tbl.push_back(mk(0, 1, 0, 4'b1000, pk(22, 0, 6, 0)));
    tbl.push_back(mk(0, 1, 0, 4'b1000, pk(23, 0, 6, 0)));
    tbl.push_back(mk(0, 1, 0, 4'b1000, pk(0, 0, 6, 0)));   // 23+1 wraps
    tbl.push_back(mk(0, 0, 1, 4'b0101, pk(0, 10, 6, 0)));  // min beats ms
    tbl.push_back(mk(0, 0, 1, 4'b0001, pk(0, 10, 6, 10)));
    tbl.push_back(mk(0, 1, 1, 4'b0001, pk(0, 10, 6, 21)));
    tbl.push_back(mk(0, 1, 0, 4'b0000, pk(0, 10, 6, 21))); // no field selected

    // Reset state
    step();
    step();
    chk_all("reset_hold", pk(0, 0, 0, 0), 1'b0, 1'b0);
    #2 reset = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].tog, tbl[i].one, tbl[i].ten, tbl[i].sw);
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].t, tbl[i].run, tbl[i].dn);
      drive(1'b0, 1'b0, 1'b0, 4'b0000);
      step();
    end

    // Toggle and add on the same edge: run starts, add discarded
    drive(1'b1, 1'b1, 1'b0, 4'b0001);
    step();
    chk_all("start_discard_add", pk(0, 10, 6, 21), 1'b1, 1'b0);
    // Add edge while running is ignored (no tick on this edge)
    drive(1'b0, 1'b1, 1'b0, 4'b0001);
    step();
    chk_t("run_add_ignored", out_time, pk(0, 10, 6, 21));
    drive(1'b0, 1'b0, 1'b0, 4'b0000);
    step();
    chk_t("run_tick1", out_time, pk(0, 10, 6, 20));
    step();
    // Pause with prescaler mid-count
    drive(1'b1, 1'b0, 1'b0, 4'b0000);
    step();
    chk_all("pause", pk(0, 10, 6, 20), 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 50; i++) begin
      step();
      chk_t($sformatf("pause_frozen%0d", i), out_time, pk(0, 10, 6, 20));
    end
    pulse(1'b0, 1'b1, 1'b0, 4'b1000);
    chk_all("pause_edit_hr", pk(1, 10, 6, 20), 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'b0000);
    step();
    chk_all("resume", pk(1, 10, 6, 20), 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'b0000);
    step();
    chk_t("resume_partial_tick", out_time, pk(1, 10, 6, 19));
    step();

    // Asynchronous reset mid-run, checked before any clock edge
    #2 reset = 1'b0;
    #1;
    chk_all("async_reset", pk(0, 0, 0, 0), 1'b0, 1'b0);
    step();
    #2 reset = 1'b1;

    // Hour borrow: 01:00:00.00 -> 00:59:59.99
    pulse(1'b0, 1'b1, 1'b0, 4'b1000);
    chk_t("set_1h", out_time, pk(1, 0, 0, 0));
    drive(1'b1, 1'b0, 1'b0, 4'b0000);
    step();
    chk_b("run_1h.running", running, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 4'b0000);
    step();
    chk_t("run_1h_pretick", out_time, pk(1, 0, 0, 0));
    step();
    chk_all("borrow_chain", pk(0, 59, 59, 99), 1'b1, 1'b0);

    do_reset();

    // Expiry from 00:00:01.00 at two clocks per tick
    pulse(1'b0, 1'b1, 1'b0, 4'b0010);
    chk_t("set_1s", out_time, pk(0, 0, 1, 0));
    drive(1'b1, 1'b0, 1'b0, 4'b0000);
    step();
    chk_all("run_1s", pk(0, 0, 1, 0), 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'b0000);
    repeat (199) step();
    chk_all("pre_expiry", pk(0, 0, 0, 1), 1'b1, 1'b0);
    step();
    chk_all("expiry", pk(0, 0, 0, 0), 1'b0, 1'b1);
    step();
    chk_all("done_hold", pk(0, 0, 0, 0), 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 4'b0000);
    chk_all("ack_to_set", pk(0, 0, 0, 0), 1'b0, 1'b0);
    // Back in SET: editing works again
    pulse(1'b0, 1'b0, 1'b1, 4'b0100);
    chk_all("set_after_ack", pk(0, 10, 0, 0), 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
